// File: rtl/irq_sched_pkg.sv
// Shared types and constants for the interrupt scheduler.
// Holds FSM state codes, mcause layout and the priority encoder.
package irq_sched_pkg;

    localparam int IRQS_STATE_BUS = 2;
    localparam int MCAUSE_INT_BIT = 31;
    localparam int CLOCK_IRQ_PIN  = 0;

    typedef enum logic [IRQS_STATE_BUS-1:0] {
        IRQS_IDLE    = 2'd0,
        IRQS_REQ     = 2'd1,
        IRQS_SERVICE = 2'd2
    } irqs_state_e;

    // Lowest set index wins; MSB of result flags "any set".
    function automatic logic [4:0] prio_enc(input logic [15:0] v);
        logic [4:0] res;
        res = 5'd0;
        for (int i = 15; i >= 0; i--) begin
            if (v[i]) res = {1'b1, 4'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/irq_sync.sv
// Per-source synchroniser chain with rising-edge detect.
// Outputs the synchronised level and a one-cycle rise flag.
module irq_sync
    import irq_sched_pkg::*;
#(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [N-1:0] irq_src,
    output logic [N-1:0] sync_lvl,
    output logic [N-1:0] rise
);

    logic [STAGES-1:0] sh_q [N];
    logic [N-1:0]      prev_q;

    for (genvar g = 0; g < N; g++) begin : g_src
        // Shift the raw line through the synchroniser flops.
        always_ff @(posedge clk or negedge clr) begin
            if (!clr) sh_q[g] <= '0;
            else      sh_q[g] <= {sh_q[g][STAGES-2:0], irq_src[g]};
        end
        assign sync_lvl[g] = sh_q[g][STAGES-1];
    end

    // Remember last synchronised level for edge detection.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) prev_q <= '0;
        else      prev_q <= sync_lvl;
    end

    assign rise = sync_lvl & ~prev_q;

endmodule

// File: rtl/irq_sched.sv
// Interrupt scheduler: pending latch, fixed priority pick and
// req/ack/done handshake to the trap client (no nesting).
module irq_sched
    import irq_sched_pkg::*;
#(
    parameter int               N_IRQ       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [N_IRQ-1:0] EDGE_MASK   = N_IRQ'(1 << CLOCK_IRQ_PIN),
    parameter int               CAUSE_BASE  = 7
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [N_IRQ-1:0] irq_src,
    input  logic [N_IRQ-1:0] mie,
    input  logic             global_int_en,
    input  logic             int_ack,
    input  logic             int_done,
    output logic             int_req,
    output logic [3:0]       int_id,
    output logic [31:0]      int_cause,
    output logic [N_IRQ-1:0] irq_pending
);

    irqs_state_e      state_q, state_d;
    logic             req_q, req_d;
    logic [3:0]       id_q, id_d;
    logic [31:0]      cause_q, cause_d;
    logic [N_IRQ-1:0] sync_lvl, rise;
    logic [N_IRQ-1:0] pend_edge_q, ack_clr;
    logic [N_IRQ-1:0] pending, eligible;
    logic [15:0]      elig16;
    logic [4:0]       pick;
    logic [31:0]      win_cause;

    irq_sync #(
        .N      (N_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk      (clk),
        .clr      (clr),
        .irq_src  (irq_src),
        .sync_lvl (sync_lvl),
        .rise     (rise)
    );

    // Clear mask for the acknowledged edge source.
    always_comb begin
        ack_clr = '0;
        if (state_q == IRQS_REQ && int_ack)
            ack_clr = N_IRQ'(1) << id_q;
    end

    // Edge pendings: a fresh rise beats a same-cycle ack clear.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) pend_edge_q <= '0;
        else      pend_edge_q <= ((pend_edge_q & ~ack_clr) | rise) & EDGE_MASK;
    end

    assign pending  = (pend_edge_q & EDGE_MASK) | (sync_lvl & ~EDGE_MASK);
    assign eligible = pending & mie & {N_IRQ{global_int_en}};
    assign elig16   = 16'(eligible);
    assign pick     = prio_enc(elig16);

    // mcause for the current winner, interrupt bit set.
    always_comb begin
        win_cause = '0;
        win_cause[30:0] = 31'(CAUSE_BASE) + 31'(pick[3:0]);
        win_cause[MCAUSE_INT_BIT] = 1'b1;
    end

    // Next state and registered handshake outputs.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        id_d    = id_q;
        cause_d = cause_q;
        unique case (state_q)
            IRQS_IDLE: begin
                if (pick[4]) begin
                    state_d = IRQS_REQ;
                    req_d   = 1'b1;
                    id_d    = pick[3:0];
                    cause_d = win_cause;
                end
            end
            IRQS_REQ: begin
                if (int_ack) begin
                    state_d = IRQS_SERVICE;
                    req_d   = 1'b0;
                end else if (!elig16[id_q]) begin
                    state_d = IRQS_IDLE;
                    req_d   = 1'b0;
                end
            end
            IRQS_SERVICE: begin
                req_d = 1'b0;
                if (int_done) state_d = IRQS_IDLE;
            end
            default: begin
                state_d = IRQS_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // FSM state and output registers.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q <= IRQS_IDLE;
            req_q   <= 1'b0;
            id_q    <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            id_q    <= id_d;
            cause_q <= cause_d;
        end
    end

    assign int_req     = req_q;
    assign int_id      = id_q;
    assign int_cause   = cause_q;
    assign irq_pending = pending;

endmodule

// File: tb/tb_irq_sched.sv
// Directed bench for irq_sched: latency, priority, withdraw,
// set-vs-clear, ack/done collision and async reset.
module tb_irq_sched;

    logic        clk = 1'b0;
    logic        clr;
    logic [7:0]  irq_src;
    logic [7:0]  mie;
    logic        global_int_en;
    logic        int_ack;
    logic        int_done;
    logic        int_req;
    logic [3:0]  int_id;
    logic [31:0] int_cause;
    logic [7:0]  irq_pending;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    irq_sched dut (
        .clk           (clk),
        .clr           (clr),
        .irq_src       (irq_src),
        .mie           (mie),
        .global_int_en (global_int_en),
        .int_ack       (int_ack),
        .int_done      (int_done),
        .int_req       (int_req),
        .int_id        (int_id),
        .int_cause     (int_cause),
        .irq_pending   (irq_pending)
    );

    task automatic apply_reset();
        @(negedge clk);
        clr      = 1'b0;
        irq_src  = 8'h00;
        int_ack  = 1'b0;
        int_done = 1'b0;
        #2;
        clr = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        clr = 1'b0; irq_src = 8'hFF; mie = 8'hFF;
        global_int_en = 1'b0; int_ack = 1'b0; int_done = 1'b0;
        #1;
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL reset_req got %0b want 0", int_req);
        end
        n_run++;
        if (int_id !== 4'd0) begin
            n_fail++; $display("FAIL reset_id got %0d want 0", int_id);
        end
        n_run++;
        if (int_cause !== 32'h0) begin
            n_fail++; $display("FAIL reset_cause got %h want 0", int_cause);
        end
        repeat (2) @(negedge clk);
        n_run++;
        if (irq_pending !== 8'h00) begin
            n_fail++; $display("FAIL reset_pend got %h want 00", irq_pending);
        end
        clr = 1'b1;
        repeat (6) @(negedge clk);
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL gie_off_req got %0b want 0", int_req);
        end
        n_run++;
        if (irq_pending !== 8'hFF) begin
            n_fail++; $display("FAIL gie_off_pend got %h want ff", irq_pending);
        end
        apply_reset();
    endtask

    task automatic test_edge_latency();
        mie = 8'hFF; global_int_en = 1'b1;
        irq_src = 8'h01;
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            n_run++;
            if (int_req !== 1'b0) begin
                n_fail++; $display("FAIL edge_early c%0d got %0b want 0", i, int_req);
            end
        end
        @(negedge clk);
        n_run++;
        if (int_req !== 1'b1) begin
            n_fail++; $display("FAIL edge_req got %0b want 1", int_req);
        end
        n_run++;
        if (int_id !== 4'd0) begin
            n_fail++; $display("FAIL edge_id got %0d want 0", int_id);
        end
        n_run++;
        if (int_cause !== 32'h8000_0007) begin
            n_fail++; $display("FAIL edge_cause got %h want 80000007", int_cause);
        end
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL edge_ack_req got %0b want 0", int_req);
        end
        n_run++;
        if (irq_pending !== 8'h00) begin
            n_fail++; $display("FAIL edge_ack_pend got %h want 00", irq_pending);
        end
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
        irq_src  = 8'h00;
        apply_reset();
    endtask

    task automatic test_priority();
        irq_src = 8'h28;
        repeat (2) @(negedge clk);
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL prio_early got %0b want 0", int_req);
        end
        @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd3) begin
            n_fail++;
            $display("FAIL prio_first got req=%0b id=%0d want req=1 id=3", int_req, int_id);
        end
        n_run++;
        if (int_cause !== 32'h8000_000A) begin
            n_fail++; $display("FAIL prio_cause3 got %h want 8000000a", int_cause);
        end
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        irq_src = 8'h20;
        repeat (3) @(negedge clk);
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL prio_service got %0b want 0", int_req);
        end
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL prio_done_idle got %0b want 0", int_req);
        end
        @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd5) begin
            n_fail++;
            $display("FAIL prio_second got req=%0b id=%0d want req=1 id=5", int_req, int_id);
        end
        n_run++;
        if (int_cause !== 32'h8000_000C) begin
            n_fail++; $display("FAIL prio_cause5 got %h want 8000000c", int_cause);
        end
        apply_reset();
    endtask

    task automatic test_withdraw();
        irq_src = 8'h10;
        repeat (3) @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd4) begin
            n_fail++;
            $display("FAIL wd_req got req=%0b id=%0d want req=1 id=4", int_req, int_id);
        end
        irq_src = 8'h00;
        repeat (2) @(negedge clk);
        n_run++;
        if (int_req !== 1'b1) begin
            n_fail++; $display("FAIL wd_hold got %0b want 1", int_req);
        end
        @(negedge clk);
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL wd_drop got %0b want 0", int_req);
        end
        int_ack = 1'b1; int_done = 1'b1;
        @(negedge clk);
        int_ack = 1'b0; int_done = 1'b0;
        @(negedge clk);
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL wd_idle_ack got %0b want 0", int_req);
        end
        irq_src = 8'h10;
        repeat (3) @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd4) begin
            n_fail++;
            $display("FAIL wd_rereq got req=%0b id=%0d want req=1 id=4", int_req, int_id);
        end
        apply_reset();
    endtask

    task automatic test_set_vs_clear();
        irq_src = 8'h01;
        repeat (4) @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd0) begin
            n_fail++;
            $display("FAIL svc_req got req=%0b id=%0d want req=1 id=0", int_req, int_id);
        end
        irq_src = 8'h00;
        @(negedge clk);
        irq_src = 8'h01;
        repeat (2) @(negedge clk);
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL svc_ack got %0b want 0", int_req);
        end
        n_run++;
        if (irq_pending !== 8'h01) begin
            n_fail++; $display("FAIL svc_keep got %h want 01", irq_pending);
        end
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
        n_run++;
        if (int_req !== 1'b0) begin
            n_fail++; $display("FAIL svc_done got %0b want 0", int_req);
        end
        @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd0) begin
            n_fail++;
            $display("FAIL svc_second got req=%0b id=%0d want req=1 id=0", int_req, int_id);
        end
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        n_run++;
        if (irq_pending !== 8'h00) begin
            n_fail++; $display("FAIL svc_clear got %h want 00", irq_pending);
        end
        apply_reset();
    endtask

    task automatic test_ack_done_same();
        irq_src = 8'h44;
        repeat (3) @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd2) begin
            n_fail++;
            $display("FAIL ad_req got req=%0b id=%0d want req=1 id=2", int_req, int_id);
        end
        int_ack = 1'b1; int_done = 1'b1;
        @(negedge clk);
        int_ack = 1'b0; int_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_run++;
            if (int_req !== 1'b0) begin
                n_fail++; $display("FAIL ad_service c%0d got %0b want 0", i, int_req);
            end
        end
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
        @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd2) begin
            n_fail++;
            $display("FAIL ad_rereq got req=%0b id=%0d want req=1 id=2", int_req, int_id);
        end
        apply_reset();
    endtask

    task automatic test_async_reset();
        irq_src = 8'h08;
        repeat (3) @(negedge clk);
        n_run++;
        if (int_req !== 1'b1 || int_id !== 4'd3) begin
            n_fail++;
            $display("FAIL ar_req got req=%0b id=%0d want req=1 id=3", int_req, int_id);
        end
        int_ack = 1'b1;
        @(negedge clk);
        int_ack = 1'b0;
        irq_src = 8'h0A;
        repeat (3) @(negedge clk);
        n_run++;
        if (irq_pending !== 8'h0A) begin
            n_fail++; $display("FAIL ar_pend got %h want 0a", irq_pending);
        end
        @(posedge clk);
        #2;
        clr = 1'b0;
        #1;
        n_run++;
        if (int_id !== 4'd0 || int_cause !== 32'h0) begin
            n_fail++;
            $display("FAIL ar_zero got id=%0d cause=%h want 0/0", int_id, int_cause);
        end
        n_run++;
        if (irq_pending !== 8'h00 || int_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ar_clear got pend=%h req=%0b want 00/0", irq_pending, int_req);
        end
        irq_src = 8'h00;
        @(negedge clk);
        clr = 1'b1;
        int_done = 1'b1;
        @(negedge clk);
        int_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_run++;
            if (int_req !== 1'b0) begin
                n_fail++; $display("FAIL ar_after c%0d got %0b want 0", i, int_req);
            end
        end
    endtask

    initial begin
        test_reset();
        test_edge_latency();
        test_priority();
        test_withdraw();
        test_set_vs_clear();
        test_ack_done_same();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
